debounce_multi: RTL and testbench

- N-channel debouncer for push-buttons and switches.
- Each channel synchronises a raw asynchronous input and filters it with a parametrised stability counter. It outputs a clean level plus one-cycle press and release pulses.
- Optional auto-repeat mode emits periodic pulses while a button is held.
- Sits between board pins and control FSMs: reset generation, mode select, counters.

---
 rtl/debounce_multi_if.sv | 22 ++
 rtl/debounce_multi.sv | 124 ++++++++++++
 tb/tb_debounce_multi.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Pin-side button inputs and debounced event outputs of debounce_multi.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  // Release pulse; named rel because 'release' is a reserved word.
  logic [N_CH-1:0] rel;
  logic [N_CH-1:0] rep;
  logic            any_press;

  modport master (
    output btn_in,
    input  level, press, rel, rep, any_press
  );

  modport slave (
    input  btn_in,
    output level, press, rel, rep, any_press
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-flop synchroniser, stability counter,
// press/release pulses and optional auto-repeat per channel.
module debounce_multi #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input logic         clk,
  input logic         rst_n,
  debounce_multi_if.slave bus
);

  localparam int unsigned CntW   = $clog2(STABLE_CYCLES);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW  = $clog2(RepMax);

  if (N_CH < 1 || N_CH > 32 || STABLE_CYCLES < 2 || REPEAT_EN > 1 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("debounce_multi: illegal parameter value");
  end

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q [N_CH];
  logic [CntW-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic            any_press_q;

  // Stability filter: level follows the synchronised input only after
  // STABLE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(STABLE_CYCLES - 1)) begin
        cnt_d[i]   = '0;
        level_d[i] = sync2_q[i];
        press_d[i] = sync2_q[i];
        rel_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Synchroniser, filter state and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      rel_q       <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= bus.btn_in;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      any_press_q <= |press_q;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  if (REPEAT_EN != 0) begin : g_rep
    logic [RcntW-1:0] rcnt_q [N_CH];
    logic [RcntW-1:0] rcnt_d [N_CH];
    logic [N_CH-1:0]  phase_q, phase_d;
    logic [N_CH-1:0]  rep_q, rep_d;

    // Repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD; any level
    // edge restarts it, so rep cannot coincide with press or release.
    always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
        rcnt_d[i]  = rcnt_q[i];
        phase_d[i] = phase_q[i];
        rep_d[i]   = 1'b0;
        if (press_d[i] || rel_d[i] || !level_q[i]) begin
          rcnt_d[i]  = '0;
          phase_d[i] = 1'b0;
        end else if (rcnt_q[i] == (phase_q[i] ? RcntW'(REPEAT_PERIOD - 1)
                                              : RcntW'(REPEAT_DELAY - 1))) begin
          rcnt_d[i]  = '0;
          phase_d[i] = 1'b1;
          rep_d[i]   = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        phase_q <= '0;
        rep_q   <= '0;
        for (int i = 0; i < int'(N_CH); i++) rcnt_q[i] <= '0;
      end else begin
        phase_q <= phase_d;
        rep_q   <= rep_d;
        for (int i = 0; i < int'(N_CH); i++) rcnt_q[i] <= rcnt_d[i];
      end
    end

    assign bus.rep = rep_q;
  end else begin : g_no_rep
    assign bus.rep = '0;
  end

  assign bus.level     = level_q;
  assign bus.press     = press_q;
  assign bus.rel       = rel_q;
  assign bus.any_press = any_press_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: one auto-repeat build, one without.
module tb_debounce_multi;
  localparam int unsigned NCh = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCh-1:0] btn = '0;
  int             n_vec = 0;
  int             n_err = 0;
  logic [NCh-1:0] acc;
  logic [NCh-1:0] rep1_seen = '0;

  always #5 clk = ~clk;

  debounce_multi_if #(.N_CH(NCh)) bus0 ();
  debounce_multi_if #(.N_CH(NCh)) bus1 ();

  assign bus0.btn_in = btn;
  assign bus1.btn_in = btn;

  debounce_multi #(
    .N_CH(NCh), .STABLE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  debounce_multi #(
    .N_CH(NCh), .STABLE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_norep (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Sticky record of any rep pulse from the no-repeat build.
  always @(negedge clk) rep1_seen <= rep1_seen | bus1.rep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_level", 32'(bus0.level), 0);
    check("rst_press", 32'(bus0.press), 0);
    check("rst_rel", 32'(bus0.rel), 0);
    check("rst_rep", 32'(bus0.rep), 0);
    check("rst_any", 32'(bus0.any_press), 0);
    rst_n = 1'b1;
    tick(3);

    // Clean press on ch0, then release before any repeat is due
    btn = 4'b0001;
    tick(5);
    check("t1_level_e5", 32'(bus0.level), 0);
    tick();
    check("t1_level_e6", 32'(bus0.level), 32'b0001);
    check("t1_press_e6", 32'(bus0.press), 32'b0001);
    check("t1_norep_press_e6", 32'(bus1.press), 32'b0001);
    check("t1_any_e6", 32'(bus0.any_press), 0);
    tick();
    check("t1_press_e7", 32'(bus0.press), 0);
    check("t1_any_e7", 32'(bus0.any_press), 1);
    btn = 4'b0000;
    tick(5);
    check("t1_rel_e5", 32'(bus0.rel), 0);
    tick();
    check("t1_rel_e6", 32'(bus0.rel), 32'b0001);
    check("t1_norep_rel_e6", 32'(bus1.rel), 32'b0001);
    check("t1_level_rel", 32'(bus0.level), 0);
    tick(4);

    // Glitch rejection on ch1: high 3 cycles, low 1, then held high
    btn = 4'b0010;
    acc = '0;
    tick(3);
    acc |= bus0.level | bus0.press;
    btn = 4'b0000;
    tick();
    acc |= bus0.level | bus0.press;
    btn = 4'b0010;
    for (int k = 5; k <= 9; k++) begin
      tick();
      acc |= bus0.level | bus0.press;
    end
    check("t2_glitch_quiet", 32'(acc), 0);
    tick();
    check("t2_level_e10", 32'(bus0.level), 32'b0010);
    check("t2_press_e10", 32'(bus0.press), 32'b0010);
    btn = 4'b0000;
    tick(6);
    check("t2_rel", 32'(bus0.rel), 32'b0010);
    tick(4);

    // Auto-repeat on ch2: press at P, rep at P+10, P+13, P+16, P+19
    btn = 4'b0100;
    tick(6);
    check("t3_press_P", 32'(bus0.press), 32'b0100);
    check("t3_rep_P", 32'(bus0.rep), 0);
    acc = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      acc |= bus0.rep;
    end
    check("t3_rep_quiet", 32'(acc), 0);
    tick();
    check("t3_rep_P10", 32'(bus0.rep), 32'b0100);
    tick();
    check("t3_rep_P11", 32'(bus0.rep), 0);
    tick(2);
    check("t3_rep_P13", 32'(bus0.rep), 32'b0100);
    tick(3);
    check("t3_rep_P16", 32'(bus0.rep), 32'b0100);
    btn = 4'b0000;
    tick(3);
    check("t3_rep_P19", 32'(bus0.rep), 32'b0100);
    tick(2);
    check("t3_rel_P21", 32'(bus0.rel), 0);
    tick();
    check("t3_rel_P22", 32'(bus0.rel), 32'b0100);
    check("t3_rep_P22", 32'(bus0.rep), 0);
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc |= bus0.rep;
    end
    check("t3_rep_after_rel", 32'(acc), 0);

    // Simultaneous channels
    btn = 4'b1111;
    tick(6);
    check("t4_press_all", 32'(bus0.press), 32'b1111);
    check("t4_level_all", 32'(bus0.level), 32'b1111);
    tick();
    check("t4_any", 32'(bus0.any_press), 1);
    btn = 4'b0111;
    tick(5);
    check("t4_rel_early", 32'(bus0.rel), 0);
    tick();
    check("t4_rel_ch3", 32'(bus0.rel), 32'b1000);
    check("t4_level_ch3", 32'(bus0.level), 32'b0111);

    // Asynchronous reset mid-count on ch1 while ch0 is high
    btn = 4'b0101;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(bus0.level), 0);
    check("t5_async_press", 32'(bus0.press), 0);
    check("t5_async_rel", 32'(bus0.rel), 0);
    check("t5_async_rep", 32'(bus0.rep), 0);
    check("t5_async_any", 32'(bus0.any_press), 0);
    btn = 4'b0001;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t5_press_e5", 32'(bus0.press), 0);
    tick();
    check("t5_press_e6", 32'(bus0.press), 32'b0001);
    check("t5_norep_press_e6", 32'(bus1.press), 32'b0001);

    // No-repeat build must never have pulsed rep, including long holds above
    tick(50);
    check("t6_norep_rep", 32'(rep1_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
